// File: rtl/axi_sram_write_slave_pkg.sv
// Shared AXI write-slave definitions: widths, burst/response encodings, FSM states.
package axi_sram_write_slave_pkg;

  localparam int unsigned AXI_IDS_BITS  = 8;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 4;
  localparam int unsigned AXI_SIZE_BITS = 3;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_STRB_BITS = 4;

  localparam logic [AXI_SIZE_BITS-1:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  // Only 4-byte beats with FIXED or INCR bursts are served.
  function automatic logic aw_illegal(logic [AXI_SIZE_BITS-1:0] size, logic [1:0] burst);
    return (size != SIZE_4B) || burst[1];
  endfunction

endpackage

// File: rtl/axi_sram_write_slave_addr_gen.sv
// Burst address register and beat counter; shared with the read-side slave.
module axi_burst_addr_gen
  import axi_sram_write_slave_pkg::*;
#(
  parameter int unsigned AW    = 14,
  parameter int unsigned LEN_W = AXI_LEN_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [AW-1:0]    start_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       burst,
  input  logic             advance,
  output logic [AW-1:0]    addr,
  output logic             is_last
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       burst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      burst_q <= BURST_FIXED;
    end else if (load) begin
      addr    <= start_addr;
      cnt_q   <= '0;
      len_q   <= len;
      burst_q <= burst;
    end else if (advance) begin
      cnt_q <= cnt_q + 1'b1;
      // INCR wraps naturally at the word-address width
      if (burst_q == BURST_INCR)
        addr <= addr + 1'b1;
    end
  end

  assign is_last = (cnt_q == len_q);

endmodule

// File: rtl/axi_sram_write_slave.sv
// AXI write slave: one AW, its W burst written to a synchronous SRAM port, one B.
module axi_sram_write_slave
  import axi_sram_write_slave_pkg::*;
#(
  parameter int unsigned ID_W   = AXI_IDS_BITS,
  parameter int unsigned MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb
);

  wstate_e state_q;
  logic    err_q;
  logic    is_last;
  logic    aw_hs;
  logic    w_hs;
  logic    burst_done;
  logic    final_err;
  logic    unused_addr_bits;

  assign aw_hs      = AWVALID & AWREADY;
  assign w_hs       = WVALID & WREADY;
  // Either WLAST or the LEN-th beat ends the burst; disagreement is an error.
  assign burst_done = w_hs & (WLAST | is_last);
  assign final_err  = err_q | (WLAST ^ is_last);

  assign unused_addr_bits = ^{AWADDR[31:MEM_AW+2], AWADDR[1:0]};

  axi_burst_addr_gen #(
    .AW    (MEM_AW),
    .LEN_W (AXI_LEN_BITS)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (aw_hs),
    .start_addr (AWADDR[MEM_AW+1:2]),
    .len        (AWLEN),
    .burst      (AWBURST),
    .advance    (w_hs),
    .addr       (mem_addr),
    .is_last    (is_last)
  );

  assign mem_we    = w_hs & ~err_q;
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (aw_hs) begin
            BID     <= AWID;
            err_q   <= aw_illegal(AWSIZE, AWBURST);
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (burst_done) begin
            err_q   <= final_err;
            BRESP   <= final_err ? RESP_SLVERR : RESP_OKAY;
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            state_q <= W_IDLE;
          end
        end
        default: begin
          AWREADY <= 1'b1;
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
          state_q <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Self-checking bench for axi_sram_write_slave: directed table, reset case, random bursts.
module tb_axi_sram_write_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  axi_sram_write_slave #(.ID_W(8), .MEM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlast;
    logic [31:0] gap;
    int          bhold;
    int          sbeat;
    logic [3:0]  sval;
    int          exp_nwr;
    logic [13:0] exp_a0;
    logic [13:0] exp_alast;
    logic [1:0]  exp_bresp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [31:0] cur_data[20];
  logic [3:0]  cur_strb[20];
  vec_t        vecs[8];

  always @(negedge clk)
    if (mem_we) got_q.push_back('{a: mem_addr, d: mem_wdata, s: mem_wstrb});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One complete transaction; the expected writes and response come from the
  // protocol rules applied to the burst as a whole.
  task automatic run_txn(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int wlast,
                         input logic [31:0] gap, input int bhold,
                         output int nwr, output logic [13:0] a0, output logic [13:0] alast,
                         output logic [1:0] bresp);
    bit          bad_aw;
    int          term, noffer, b;
    bit          hs, done;
    logic [1:0]  exp_bresp;
    logic [13:0] base;

    bad_aw    = (size != 3'b010) || burst[1];
    term      = (wlast >= 0 && wlast <= int'(len)) ? wlast : int'(len);
    noffer    = (wlast >= 0 && wlast <= int'(len)) ? wlast + 1 : int'(len) + 3;
    exp_bresp = (bad_aw || wlast != int'(len)) ? 2'b10 : 2'b00;
    base      = addr[15:2];
    exp_q.delete();
    if (!bad_aw)
      for (int i = 0; i <= term; i++)
        exp_q.push_back('{a: (burst == 2'b01) ? 14'((int'(base) + i) % 16384) : base,
                          d: cur_data[i], s: cur_strb[i]});
    got_q.delete();
    nwr = 0; a0 = '0; alast = '0; bresp = 2'b11;

    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (AWREADY) begin hs = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!hs) begin
      chk("aw_timeout", 0, 1);
      AWVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    AWVALID = 1'b0;

    b = 0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      WVALID = (b < noffer) && (c >= 32 || gap[c]);
      WDATA  = cur_data[b];
      WSTRB  = cur_strb[b];
      WLAST  = (b == wlast);
      @(negedge clk);
      if (c == 0) chk("awready_in_data", AWREADY, 0);
      if (BVALID) done = 1'b1;
      else if (WVALID && WREADY) b++;
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    if (!done) begin
      chk("b_timeout", 0, 1);
      return;
    end
    chk("beats_accepted", b, term + 1);

    for (int h = 0; h < bhold; h++) begin
      @(negedge clk);
      chk("hold_bvalid", BVALID, 1);
      chk("hold_bid", BID, id);
      chk("hold_bresp", BRESP, exp_bresp);
      chk("hold_awready", AWREADY, 0);
      chk("hold_wready", WREADY, 0);
      @(posedge clk); #1;
    end
    BREADY = 1'b1;
    @(negedge clk);
    chk("bvalid", BVALID, 1);
    chk("bid", BID, id);
    chk("bresp", BRESP, exp_bresp);
    bresp = BRESP;
    @(posedge clk); #1;
    BREADY = 1'b0;
    @(negedge clk);
    chk("awready_after_b", AWREADY, 1);
    chk("bvalid_after_b", BVALID, 0);

    chk("write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("write%0d", i), got_q[i], exp_q[i]);
    nwr = got_q.size();
    if (nwr > 0) begin
      a0    = got_q[0].a;
      alast = got_q[nwr-1].a;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          nwr;
    logic [13:0] a0, alast;
    logic [1:0]  br;
    logic [3:0]  rl;
    int          rw;

    rst = 1'b1; AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01;
    WDATA = '0; WSTRB = '0;

    vecs[0] = '{8'h15, 32'h10,   4'd0, 3'b010, 2'b01,  0, 32'hFFFFFFFF, 0, -1, 4'hF, 1, 14'h4,    14'h4,    2'b00};
    vecs[1] = '{8'h21, 32'h100,  4'd3, 3'b010, 2'b01,  3, 32'hFFFFFFED, 0,  2, 4'h3, 4, 14'h40,   14'h43,   2'b00};
    vecs[2] = '{8'h33, 32'h20,   4'd2, 3'b010, 2'b00,  2, 32'hFFFFFFFF, 1, -1, 4'hF, 3, 14'h8,    14'h8,    2'b00};
    vecs[3] = '{8'h44, 32'h40,   4'd1, 3'b010, 2'b10,  1, 32'hFFFFFFFF, 0, -1, 4'hF, 0, 14'h0,    14'h0,    2'b10};
    vecs[4] = '{8'h55, 32'h200,  4'd3, 3'b010, 2'b01,  1, 32'hFFFFFFFF, 0, -1, 4'hF, 2, 14'h80,   14'h81,   2'b10};
    vecs[5] = '{8'h66, 32'hFFFC, 4'd1, 3'b010, 2'b01,  1, 32'hFFFFFFFF, 5, -1, 4'hF, 2, 14'h3FFF, 14'h0,    2'b00};
    vecs[6] = '{8'h77, 32'h80,   4'd0, 3'b011, 2'b01,  0, 32'hFFFFFFFF, 2, -1, 4'hF, 0, 14'h0,    14'h0,    2'b10};
    vecs[7] = '{8'h88, 32'h400,  4'd2, 3'b010, 2'b01, -1, 32'hFFFFFFFA, 0, -1, 4'hF, 3, 14'h100,  14'h102,  2'b10};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", AWREADY, 1);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bid", BID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_mem_we", mem_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[v]) begin
      for (int i = 0; i < 20; i++) begin
        cur_data[i] = 32'hDEADBEEF + 32'h01010101 * i;
        cur_strb[i] = (i == vecs[v].sbeat) ? vecs[v].sval : 4'hF;
      end
      run_txn(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
              vecs[v].wlast, vecs[v].gap, vecs[v].bhold, nwr, a0, alast, br);
      chk($sformatf("vec%0d_nwr", v), nwr, vecs[v].exp_nwr);
      chk($sformatf("vec%0d_bresp", v), br, vecs[v].exp_bresp);
      if (vecs[v].exp_nwr > 0) begin
        chk($sformatf("vec%0d_a0", v), a0, vecs[v].exp_a0);
        chk($sformatf("vec%0d_alast", v), alast, vecs[v].exp_alast);
      end
      if (vecs[v].sbeat >= 0 && got_q.size() > vecs[v].sbeat)
        chk($sformatf("vec%0d_strb", v), got_q[vecs[v].sbeat].s, vecs[v].sval);
    end

    // Reset on the second beat of a 4-beat INCR burst
    AWID = 8'h99; AWADDR = 32'h300; AWLEN = 4'd3; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b1;
    @(negedge clk);
    chk("rst_seq_awready", AWREADY, 1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    WVALID = 1'b1; WLAST = 1'b0; WDATA = 32'h1111_0000; WSTRB = 4'hF;
    @(negedge clk);
    chk("rst_seq_beat0_we", mem_we, 1);
    chk("rst_seq_beat0_addr", mem_addr, 14'hC0);
    @(posedge clk); #1;
    rst = 1'b1; WDATA = 32'h1111_0001;
    @(posedge clk); #1;
    rst = 1'b0; WVALID = 1'b0;
    @(negedge clk);
    chk("rst_seq_awready_after", AWREADY, 1);
    chk("rst_seq_wready_after", WREADY, 0);
    chk("rst_seq_bvalid_after", BVALID, 0);
    chk("rst_seq_bid_after", BID, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      cur_data[i] = 32'hCAFE0000 + i;
      cur_strb[i] = 4'hF;
    end
    run_txn(8'h5A, 32'h1000, 4'd1, 3'b010, 2'b01, 1, 32'hFFFFFFFF, 0, nwr, a0, alast, br);
    chk("post_rst_nwr", nwr, 2);
    chk("post_rst_a0", a0, 14'h400);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 20; i++) begin
        cur_data[i] = $urandom;
        cur_strb[i] = 4'($urandom);
      end
      rl = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0:       rw = -1;
        1:       rw = $urandom_range(0, int'(rl));
        default: rw = int'(rl);
      endcase
      run_txn(8'($urandom), $urandom,
              rl,
              ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010,
              ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)),
              rw, $urandom, $urandom_range(0, 3), nwr, a0, alast, br);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
